// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the fully-connected post-processing stage.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } pack_state_e;

  // Round-half-up arithmetic shift followed by saturation to a signed out_width range.
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] sum,
                                                   input int shift,
                                                   input int out_width);
    logic signed [31:0] rounded;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    rounded = (sum + (32'sd1 <<< (shift - 1))) >>> shift;
    hi      = (32'sd1 <<< (out_width - 1)) - 32'sd1;
    lo      = -(32'sd1 <<< (out_width - 1));
    if (rounded > hi) begin
      return hi;
    end
    if (rounded < lo) begin
      return lo;
    end
    return rounded;
  endfunction

endpackage

// File: rtl/fc_post_proc_sync_fifo.sv
// Single-clock FIFO with a registered head word; a push into an empty FIFO is visible next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop frees the slot the push lands in, so a full FIFO still accepts on a simultaneous pop.
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);

  assign rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // The head only moves on a pop or when the incoming word becomes the new head.
      if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
        head_q <= wr_data_i;
      end else if (do_rd) begin
        head_q <= mem_q[rd_ptr_d];
      end
    end
  end

  assign rd_data_o = head_q;

endmodule

// File: rtl/fc_post_proc.sv
// Bias add, optional ReLU, requantize, pack TILING_SIZE lanes per word and buffer words for the next layer.
module fc_post_proc #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIAS_WIDTH  = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int TILING_SIZE = 8,
  parameter int KERNEL_SIZE = 4096,
  parameter int SHIFT       = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  input  logic [BIAS_WIDTH-1:0]            bias,
  input  logic                             relu_en,
  output logic [TILING_SIZE*OUT_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             overflow,
  output logic                             layer_done
);

  import fc_pkg::*;

  localparam int SUM_W  = ((DATA_WIDTH > BIAS_WIDTH) ? DATA_WIDTH : BIAS_WIDTH) + 1;
  localparam int WORD_W = TILING_SIZE * OUT_WIDTH;
  localparam int LANE_W = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;
  localparam int NEUR_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  logic [SUM_W-1:0]     data_ext, bias_ext, s1_sum_d, s1_sum_q;
  logic                 s1_valid_q, s1_relu_q;
  logic signed [31:0]   sum_wide;
  logic [OUT_WIDTH-1:0] s2_res_d, s2_res_q;
  logic                 s2_valid_q;

  assign data_ext = {{(SUM_W-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign bias_ext = {{(SUM_W-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};
  assign s1_sum_d = data_ext + bias_ext;
  assign sum_wide = {{(32-SUM_W){s1_sum_q[SUM_W-1]}}, s1_sum_q};
  assign s2_res_d = (s1_relu_q && s1_sum_q[SUM_W-1]) ? '0
                  : OUT_WIDTH'(round_sat(sum_wide, SHIFT, OUT_WIDTH));

  // relu_en travels with its sample so the result never mixes settings across a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_relu_q  <= relu_en;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s1_valid_q;
      s2_res_q   <= s2_res_d;
    end
  end

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [NEUR_W-1:0] neuron_q, neuron_d;
  logic [WORD_W-1:0] word_q, word_d, merged_word;
  logic              lane_full, neuron_last, push;

  assign lane_full   = (lane_q == LANE_W'(TILING_SIZE-1));
  assign neuron_last = (neuron_q == NEUR_W'(KERNEL_SIZE-1));
  assign push        = s2_valid_q && (lane_full || neuron_last);

  generate
    for (genvar gi = 0; gi < TILING_SIZE; gi++) begin : g_lane
      assign merged_word[gi*OUT_WIDTH +: OUT_WIDTH] =
        (s2_valid_q && (lane_q == LANE_W'(gi))) ? s2_res_q : word_q[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  // The accumulating word is cleared on every push so a short final word carries zero lanes.
  always_comb begin
    lane_d   = lane_q;
    neuron_d = neuron_q;
    word_d   = word_q;
    if (s2_valid_q) begin
      if (push) begin
        lane_d = '0;
        word_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        word_d = merged_word;
      end
      neuron_d = neuron_last ? '0 : neuron_q + NEUR_W'(1);
    end
  end

  logic [WORD_W:0] fifo_head;
  logic            fifo_full, fifo_empty, head_last, pop;
  logic            overflow_q, overflow_d;

  sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i ({neuron_last, merged_word}),
    .rd_en_i   (out_ready),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign head_last  = fifo_head[WORD_W];
  assign pop        = !fifo_empty && out_ready;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  pack_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      neuron_q   <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      neuron_q   <= neuron_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s2_valid_q) begin
          state_d = neuron_last ? ST_DRAIN : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (s2_valid_q && neuron_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    layer_done = (state_q == ST_DRAIN) && pop && head_last;
    out_valid  = !fifo_empty;
    out_last   = !fifo_empty && head_last;
    out_data   = fifo_head[WORD_W-1:0];
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_fc_post_proc.sv
// Directed bench for fc_post_proc: lane arithmetic table, latency, partial last word,
// FIFO overflow and mid-layer reset.
module tb_fc_post_proc;

  localparam int KS = 12;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] bias;
  logic        relu_en;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overflow;
  logic        layer_done;

  always #5 clk = ~clk;

  fc_post_proc #(
    .DATA_WIDTH  (16),
    .BIAS_WIDTH  (16),
    .OUT_WIDTH   (8),
    .TILING_SIZE (8),
    .KERNEL_SIZE (KS),
    .SHIFT       (4),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .bias       (bias),
    .relu_en    (relu_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .layer_done (layer_done)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] bias;
    logic        relu;
    logic [7:0]  exp;
  } vec_t;

  vec_t        vecs [16];
  logic [63:0] exp_words [4];
  logic        exp_lasts [4];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] b, input logic r);
    in_data  = d;
    bias     = b;
    relu_en  = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_word(input string name, output logic [63:0] data,
                          output logic last, output logic done);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout out_valid actual=0 required=1", name);
      data = '0;
      last = 1'b0;
      done = 1'b0;
      return;
    end
    data      = out_data;
    last      = out_last;
    out_ready = 1'b1;
    #1;
    done = layer_done;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] w;
    logic        l;
    logic        d;

    vecs[0]  = '{16'd256,   16'd16,     1'b0, 8'h11};
    vecs[1]  = '{16'h7FFF,  16'h7FFF,   1'b0, 8'h7F};
    vecs[2]  = '{16'h8000,  16'h8000,   1'b0, 8'h80};
    vecs[3]  = '{-16'sd256, 16'd0,      1'b0, 8'hF0};
    vecs[4]  = '{-16'sd256, 16'd0,      1'b1, 8'h00};
    vecs[5]  = '{16'd32,    16'd0,      1'b0, 8'h02};
    vecs[6]  = '{16'd7,     16'd0,      1'b0, 8'h00};
    vecs[7]  = '{16'd8,     16'd0,      1'b0, 8'h01};
    vecs[8]  = '{-16'sd8,   16'd0,      1'b0, 8'h00};
    vecs[9]  = '{-16'sd9,   16'd0,      1'b0, 8'hFF};
    vecs[10] = '{16'd2032,  16'd0,      1'b0, 8'h7F};
    vecs[11] = '{16'd2040,  16'd0,      1'b0, 8'h7F};
    vecs[12] = '{-16'sd2048, 16'd0,     1'b0, 8'h80};
    vecs[13] = '{-16'sd2064, 16'd0,     1'b0, 8'h80};
    vecs[14] = '{16'd100,   -16'sd50,   1'b1, 8'h03};
    vecs[15] = '{-16'sd100, 16'd50,     1'b1, 8'h00};

    exp_words[0] = 64'h0807060504030201; exp_lasts[0] = 1'b0;
    exp_words[1] = 64'h000000000C0B0A09; exp_lasts[1] = 1'b1;
    exp_words[2] = 64'h14131211100F0E0D; exp_lasts[2] = 1'b0;
    exp_words[3] = 64'h0000000018171615; exp_lasts[3] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; bias = '0; relu_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_layer_done", 64'(layer_done), 64'd0);
    rst = 1'b0;

    // Arithmetic table: two words of eight lanes each, reset between words.
    for (int wi = 0; wi < 2; wi++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        send(vecs[wi*8+i].din, vecs[wi*8+i].bias, vecs[wi*8+i].relu);
      end
      if (wi == 0) begin
        check("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_cycle3", 64'(out_valid), 64'd1);
      end
      pop_word($sformatf("table_word%0d", wi), w, l, d);
      for (int ln = 0; ln < 8; ln++) begin
        check($sformatf("vec%0d", wi*8+ln), 64'(w[ln*8 +: 8]), 64'(vecs[wi*8+ln].exp));
      end
      check($sformatf("table_word%0d_last", wi), 64'(l), 64'd0);
    end

    // Short layer: second word is partial and tagged last.
    do_reset();
    for (int i = 0; i < KS; i++) send(16'd32, 16'd0, 1'b0);
    pop_word("layer_word0", w, l, d);
    check("layer_word0_data", w, 64'h0202020202020202);
    check("layer_word0_last", 64'(l), 64'd0);
    check("layer_word0_done", 64'(d), 64'd0);
    pop_word("layer_word1", w, l, d);
    check("layer_word1_data", w, 64'h0000000002020202);
    check("layer_word1_last", 64'(l), 64'd1);
    check("layer_word1_done", 64'(d), 64'd1);
    check("layer_done_after", 64'(layer_done), 64'd0);
    check("layer_empty_after", 64'(out_valid), 64'd0);

    // Six words against a stalled consumer: four kept in order, the rest dropped.
    do_reset();
    for (int s = 0; s < 3*KS; s++) send(16'((s+1)*16), 16'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      pop_word($sformatf("ovf_word%0d", i), w, l, d);
      check($sformatf("ovf_word%0d_data", i), w, exp_words[i]);
      check($sformatf("ovf_word%0d_last", i), 64'(l), 64'(exp_lasts[i]));
    end
    repeat (3) @(negedge clk);
    check("ovf_drained", 64'(out_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-layer with samples in flight, then a fresh word.
    for (int i = 0; i < 5; i++) send(16'd80, 16'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_overflow", 64'(overflow), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 8; i++) send(16'((i+1)*32), 16'd0, 1'b0);
    pop_word("midrst_word", w, l, d);
    check("midrst_word_data", w, 64'h100E0C0A08060402);
    check("midrst_word_last", 64'(l), 64'd0);
    repeat (4) @(negedge clk);
    check("midrst_single_word", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
